keypad_digit_loader: RTL and testbench

KEYPAD_DIGIT_LOADER -- requirements
Module: keypad_digit_loader

---
 rtl/microwave_pkg.sv | 20 ++
 rtl/keypad_digit_loader_if.sv | 26 ++
 rtl/sync_debounce.sv | 108 ++++++++++
 rtl/keypad_digit_loader.sv | 70 +++++++
 tb/tb_keypad_digit_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave keypad front end: key FSM encoding,
// BCD digit width and the default debounce length.
package microwave_pkg;

  localparam int BCD_W            = 4;
  localparam int CNT_W            = 4;
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } key_state_t;

  function automatic logic is_digit(input logic [BCD_W-1:0] c);
    return (c <= 4'd9);
  endfunction

endpackage

// File: rtl/keypad_digit_loader_if.sv
// Keypad encoder inputs, control strobes and M:SS digit outputs of the loader.
interface keypad_digit_loader_if;
  import microwave_pkg::*;

  logic [BCD_W-1:0] BCD_in;
  logic             data_valid;
  logic             load_req;
  logic             clear;
  logic [BCD_W-1:0] min_bcd;
  logic [BCD_W-1:0] sec_tens_bcd;
  logic [BCD_W-1:0] sec_ones_bcd;
  logic [1:0]       digit_count;
  logic             key_ack;
  logic             load_pulse;

  modport master (
    output BCD_in, data_valid, load_req, clear,
    input  min_bcd, sec_tens_bcd, sec_ones_bcd, digit_count, key_ack, load_pulse
  );

  modport slave (
    input  BCD_in, data_valid, load_req, clear,
    output min_bcd, sec_tens_bcd, sec_ones_bcd, digit_count, key_ack, load_pulse
  );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer for the key-present flag (code delayed alongside)
// followed by the key debounce FSM; accept pulses once per qualified press.
//
// state           | meaning
// ST_IDLE         | no key, waiting for synced valid
// ST_PRESS_WAIT   | valid seen, counting down consecutive high samples
// ST_HELD         | key accepted, waiting for release
// ST_RELEASE_WAIT | valid low, counting down consecutive low samples
module sync_debounce
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BCD_W-1:0] code_raw,
  input  logic             valid_raw,
  output logic [BCD_W-1:0] code,
  output logic             accept
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

  logic             valid_s1, valid_s2;
  logic [BCD_W-1:0] code_s1, code_s2;
  key_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
      code_s1  <= '0;
      code_s2  <= '0;
      state    <= ST_IDLE;
      cnt      <= '0;
    end else begin
      valid_s1 <= valid_raw;
      valid_s2 <= valid_s1;
      code_s1  <= code_raw;
      code_s2  <= code_s1;
      state    <= state_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // cnt holds the number of further qualifying samples still required
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_s2) begin
          if (SINGLE) begin
            accept    = 1'b1;
            state_nxt = ST_HELD;
          end else begin
            state_nxt = ST_PRESS_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_PRESS_WAIT: begin
        if (!valid_s2) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_ONE) begin
          accept    = 1'b1;
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!valid_s2) begin
          if (SINGLE) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RELEASE_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (valid_s2) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_ONE) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign code = code_s2;

endmodule

// File: rtl/keypad_digit_loader.sv
// Collects debounced keypad digits into an M:SS shift buffer and hands the
// entered time to the timer with a one-cycle load pulse.
module keypad_digit_loader
  import microwave_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  keypad_digit_loader_if.slave  kp
);

  logic [BCD_W-1:0] code;
  logic             accept;
  logic [BCD_W-1:0] min_q, tens_q, ones_q;
  logic [1:0]       count_q;
  logic             ack_q, pulse_q;
  logic             any_digit;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk       (clk),
    .reset     (reset),
    .code_raw  (kp.BCD_in),
    .valid_raw (kp.data_valid),
    .code      (code),
    .accept    (accept)
  );

  assign any_digit = |{min_q, tens_q, ones_q};

  // The buffer is emptied on the edge after the load pulse so the timer
  // sees stable digits for the whole pulse cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_q   <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      count_q <= 2'd0;
      ack_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      pulse_q <= 1'b0;
      if (kp.clear || pulse_q) begin
        min_q   <= '0;
        tens_q  <= '0;
        ones_q  <= '0;
        count_q <= 2'd0;
      end else if (kp.load_req && any_digit) begin
        pulse_q <= 1'b1;
      end else if (accept && is_digit(code)) begin
        min_q  <= tens_q;
        tens_q <= ones_q;
        ones_q <= code;
        ack_q  <= 1'b1;
        if (count_q != 2'd3) count_q <= count_q + 2'd1;
      end
    end
  end

  assign kp.min_bcd      = min_q;
  assign kp.sec_tens_bcd = tens_q;
  assign kp.sec_ones_bcd = ones_q;
  assign kp.digit_count  = count_q;
  assign kp.key_ack      = ack_q;
  assign kp.load_pulse   = pulse_q;

endmodule

// File: tb/tb_keypad_digit_loader.sv
// Bench for keypad_digit_loader: directed key scenarios plus random key
// traffic, every output compared each cycle against a run-length/queue model.
module tb_keypad_digit_loader;
  import microwave_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;

  keypad_digit_loader_if kif();

  keypad_digit_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ack_seen = 0;

  // reference model state
  bit m_p1, m_p2;
  int m_c1, m_c2;
  bit m_held;
  int m_run_hi, m_run_lo;
  int m_digs[$];
  bit m_ack, m_pulse;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_digit(input int pos);
    int idx;
    idx = m_digs.size() - 1 - pos;
    return (idx >= 0) ? m_digs[idx] : 0;
  endfunction

  function automatic bit digits_nonzero();
    foreach (m_digs[i]) if (m_digs[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update();
    bit sv, acc, was_pulse;
    int code;
    if (reset) begin
      m_p1 = 0; m_p2 = 0; m_c1 = 0; m_c2 = 0;
      m_held = 0; m_run_hi = 0; m_run_lo = 0;
      m_digs.delete();
      m_ack = 0; m_pulse = 0;
      return;
    end
    sv   = m_p2;
    code = m_c2;
    m_p2 = m_p1; m_c2 = m_c1;
    m_p1 = kif.data_valid; m_c1 = int'(kif.BCD_in);
    acc = 0;
    if (!m_held) begin
      if (sv) begin
        m_run_hi++;
        if (m_run_hi >= D) begin acc = 1; m_held = 1; m_run_lo = 0; end
      end else m_run_hi = 0;
    end else begin
      if (!sv) begin
        m_run_lo++;
        if (m_run_lo >= D) begin m_held = 0; m_run_hi = 0; end
      end else m_run_lo = 0;
    end
    was_pulse = m_pulse;
    m_pulse = 0;
    m_ack = 0;
    if (kif.clear || was_pulse) m_digs.delete();
    else if (kif.load_req && digits_nonzero()) m_pulse = 1;
    else if (acc && code <= 9) begin
      m_digs.push_back(code);
      if (m_digs.size() > 3) void'(m_digs.pop_front());
      m_ack = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_val("key_ack",     int'(kif.key_ack),      int'(m_ack));
    check_val("load_pulse",  int'(kif.load_pulse),   int'(m_pulse));
    check_val("min_bcd",     int'(kif.min_bcd),      exp_digit(2));
    check_val("sec_tens",    int'(kif.sec_tens_bcd), exp_digit(1));
    check_val("sec_ones",    int'(kif.sec_ones_bcd), exp_digit(0));
    check_val("digit_count", int'(kif.digit_count),  m_digs.size());
    if (kif.key_ack) ack_seen++;
  endtask

  task automatic press(input int code, input int hold);
    kif.BCD_in = 4'(code);
    kif.data_valid = 1'b1;
    repeat (hold) tick();
    kif.data_valid = 1'b0;
    repeat (D + 4) tick();
  endtask

  task automatic do_clear();
    kif.clear = 1'b1;
    tick();
    kif.clear = 1'b0;
  endtask

  task automatic check_time(input string tag, input int m, input int t, input int o, input int n);
    check_val({tag, "_min"},   int'(kif.min_bcd),      m);
    check_val({tag, "_tens"},  int'(kif.sec_tens_bcd), t);
    check_val({tag, "_ones"},  int'(kif.sec_ones_bcd), o);
    check_val({tag, "_count"}, int'(kif.digit_count),  n);
  endtask

  initial begin
    int n;
    int seg;
    bit lvl;
    reset = 1'b1;
    kif.BCD_in = '0; kif.data_valid = 1'b0; kif.load_req = 1'b0; kif.clear = 1'b0;
    tick(); tick();
    check_time("reset", 0, 0, 0, 0);
    check_val("reset_ack", int'(kif.key_ack), 0);
    reset = 1'b0;
    tick();

    // 5 held long, then 3, then 0
    ack_seen = 0;
    press(5, 20); press(3, 8); press(0, 8);
    check_val("s530_acks", ack_seen, 3);
    check_time("s530", 5, 3, 0, 3);

    // short glitch on data_valid
    ack_seen = 0;
    kif.BCD_in = 4'd7; kif.data_valid = 1'b1;
    tick(); tick();
    kif.data_valid = 1'b0;
    repeat (10) tick();
    check_val("glitch_acks", ack_seen, 0);
    check_time("glitch", 5, 3, 0, 3);

    // four digits, oldest discarded
    do_clear();
    ack_seen = 0;
    press(1, 6); press(2, 6); press(3, 6); press(4, 6);
    check_val("four_acks", ack_seen, 4);
    check_time("four", 2, 3, 4, 3);

    // load of 1:30, then load on empty buffer
    do_clear();
    press(1, 6); press(3, 6); press(0, 6);
    kif.load_req = 1'b1; tick(); kif.load_req = 1'b0;
    check_val("load_pulse_hi", int'(kif.load_pulse), 1);
    check_time("load_hold", 1, 3, 0, 3);
    tick();
    check_val("load_pulse_lo", int'(kif.load_pulse), 0);
    check_time("load_after", 0, 0, 0, 0);
    kif.load_req = 1'b1; tick(); kif.load_req = 1'b0;
    check_val("load_zero", int'(kif.load_pulse), 0);
    tick();

    // non-digit code, then clear beats load
    ack_seen = 0;
    press(12, 10);
    check_val("code12_acks", ack_seen, 0);
    check_time("code12", 0, 0, 0, 0);
    press(4, 6); press(0, 6); press(0, 6);
    check_time("s400", 4, 0, 0, 3);
    kif.clear = 1'b1; kif.load_req = 1'b1; tick();
    kif.clear = 1'b0; kif.load_req = 1'b0;
    check_val("clr_load_pulse", int'(kif.load_pulse), 0);
    check_time("clr_load", 0, 0, 0, 0);
    tick();
    check_val("clr_load_pulse2", int'(kif.load_pulse), 0);

    // reset mid-press: fresh debounce afterwards
    press(9, 6);
    kif.BCD_in = 4'd7; kif.data_valid = 1'b1;
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_time("midrst", 0, 0, 0, 0);
    check_val("midrst_ack", int'(kif.key_ack), 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (kif.key_ack) break;
    end
    check_val("midrst_latency", n, D + 2);
    check_time("midrst_digit", 0, 0, 7, 1);
    kif.data_valid = 1'b0;
    repeat (D + 4) tick();

    // random key traffic
    seg = 0; lvl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (seg == 0) begin
        lvl = !lvl;
        seg = $urandom_range(1, 14);
        if (lvl) kif.BCD_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                         : 4'($urandom_range(0, 9));
      end
      seg--;
      kif.data_valid = lvl;
      kif.load_req   = ($urandom_range(0, 24) == 0);
      kif.clear      = ($urandom_range(0, 59) == 0);
      reset          = ($urandom_range(0, 399) == 0);
      tick();
    end
    kif.data_valid = 1'b0; kif.load_req = 1'b0; kif.clear = 1'b0; reset = 1'b0;
    repeat (D + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
